// File: rtl/one_bit_comparator.sv
// Single-bit magnitude-comparator slice for a ripple cascade (7485 style).
// The local a/b bit pair decides the result when the bits differ. When they
// match, the verdict from the less-significant slice (in_g/in_eq/in_l) passes
// through. All outputs are registered, so each slice adds one clock of latency.
// err flags a cascade input that was not exactly one-hot in the last enabled
// cycle.
module one_bit_comparator (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic in_g,
  input  logic in_eq,
  input  logic in_l,
  output logic G,
  output logic Eq,
  output logic L,
  output logic err
);

  logic g_q,   g_d;
  logic eq_q,  eq_d;
  logic l_q,   l_d;
  logic err_q, err_d;

  // Next-state verdict: differing local bits win. Otherwise resolve the cascade
  // with priority in_g > in_l > in_eq. An all-zero cascade still yields Eq, so
  // the outputs stay one-hot even when the inputs are malformed.
  always_comb begin
    g_d  = 1'b0;
    eq_d = 1'b0;
    l_d  = 1'b0;
    if (a && !b) begin
      g_d = 1'b1;
    end else if (!a && b) begin
      l_d = 1'b1;
    end else if (in_g) begin
      g_d = 1'b1;
    end else if (in_l) begin
      l_d = 1'b1;
    end else begin
      eq_d = 1'b1;
    end
  end

  // Cascade integrity: exactly one of the three inputs must be set. This check
  // ignores a/b.
  always_comb begin
    err_d = 1'b1;
    case ({in_g, in_eq, in_l})
      3'b100, 3'b010, 3'b001: err_d = 1'b0;
      default:                err_d = 1'b1;
    endcase
  end

  // Output registers: reset takes priority over enable, and en=0 holds state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q   <= 1'b0;
      eq_q  <= 1'b1;
      l_q   <= 1'b0;
      err_q <= 1'b0;
    end else if (en) begin
      g_q   <= g_d;
      eq_q  <= eq_d;
      l_q   <= l_d;
      err_q <= err_d;
    end
  end

  assign G   = g_q;
  assign Eq  = eq_q;
  assign L   = l_q;
  assign err = err_q;

endmodule

// File: tb/tb_one_bit_comparator.sv
// Directed-vector bench for one_bit_comparator: a single slice plus a 4-slice
// ripple chain built from the same module.
module tb_one_bit_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;
  logic a, b, in_g, in_eq, in_l;
  logic G, Eq, L, err;

  one_bit_comparator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .in_g  (in_g),
    .in_eq (in_eq),
    .in_l  (in_l),
    .G     (G),
    .Eq    (Eq),
    .L     (L),
    .err   (err)
  );

  // 4-slice chain. Slice 0 is the LSB and takes in_eq=1 as its cascade input.
  logic [3:0] chain_a, chain_b;
  logic [3:0] c_g, c_eq, c_l, c_err;

  for (genvar i = 0; i < 4; i++) begin : g_chain
    logic cg_in, ceq_in, cl_in;
    if (i == 0) begin : g_lsb
      assign cg_in  = 1'b0;
      assign ceq_in = 1'b1;
      assign cl_in  = 1'b0;
    end else begin : g_up
      assign cg_in  = c_g[i-1];
      assign ceq_in = c_eq[i-1];
      assign cl_in  = c_l[i-1];
    end
    one_bit_comparator u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (chain_a[i]),
      .b     (chain_b[i]),
      .in_g  (cg_in),
      .in_eq (ceq_in),
      .in_l  (cl_in),
      .G     (c_g[i]),
      .Eq    (c_eq[i]),
      .L     (c_l[i]),
      .err   (c_err[i])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Each checked value is packed as {G, Eq, L, err}.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got {G,Eq,L,err}=%b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_v, input logic b_v,
                       input logic g_v, input logic eq_v, input logic l_v);
    a = a_v; b = b_v; in_g = g_v; in_eq = eq_v; in_l = l_v;
  endtask

  function automatic logic [3:0] dut_out();
    return {G, Eq, L, err};
  endfunction

  function automatic logic [3:0] msb_out();
    return {c_g[3], c_eq[3], c_l[3], c_err[3]};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chain_a = 4'b0000; chain_b = 4'b0000;
    #2;

    // Reset for two clocks with random inputs.
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      check($sformatf("reset_%0d", i), dut_out(), 4'b0100);
    end

    // Release reset with en=0 and a malformed, G-favouring input: state must hold.
    rst_n = 1'b1; en = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(); check("hold_after_reset_0", dut_out(), 4'b0100);
    tick(); check("hold_after_reset_1", dut_out(), 4'b0100);

    // Sweep a/b with the cascade forced to G.
    en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick(); check("sweep_00", dut_out(), 4'b1000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("sweep_01", dut_out(), 4'b0010);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick(); check("sweep_10", dut_out(), 4'b1000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("sweep_11", dut_out(), 4'b1000);

    // Pass-through with a=b=1.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick(); check("pass_eq", dut_out(), 4'b0100);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick(); check("pass_l",  dut_out(), 4'b0010);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick(); check("pass_g",  dut_out(), 4'b1000);

    // Malformed cascade inputs.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick(); check("bad_g_l",    dut_out(), 4'b1001);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick(); check("bad_l_eq",   dut_out(), 4'b0011);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(); check("bad_none",   dut_out(), 4'b0101);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(); check("bad_none_a", dut_out(), 4'b1001);

    // Enable/reset interaction: the inputs would give L with no error, but en=0 holds.
    en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); check("en0_hold_0", dut_out(), 4'b1001);
    tick(); check("en0_hold_1", dut_out(), 4'b1001);
    rst_n = 1'b0;
    tick(); check("reset_over_en0", dut_out(), 4'b0100);
    rst_n = 1'b1; en = 1'b1;

    // 4-slice chain; inputs are held for 4 clocks so the result reaches the MSB.
    chain_a = 4'b1010; chain_b = 4'b1001;
    repeat (4) tick();
    check("chain_gt", msb_out(), 4'b1000);

    chain_a = 4'b0110; chain_b = 4'b0110;
    repeat (4) tick();
    check("chain_eq", msb_out(), 4'b0100);

    chain_a = 4'b0011; chain_b = 4'b0101;
    repeat (4) tick();
    check("chain_lt", msb_out(), 4'b0010);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/one_bit_comparator.md
Name: one_bit_comparator

Overview:
- Single-bit magnitude-comparator slice, cascadable in a ripple chain to build an N-bit comparator, in the style of the 7485.
- Compares the local bit pair a/b. When they are equal, it passes through the cascade result from the less-significant slice (in_g/in_eq/in_l).
- Outputs are registered: one clock of latency per slice. Adds a hold enable and a cascade-integrity error flag.

Parameters:
- none

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  synchronous active-low reset, sampled on rising clk
- en     input   1  update enable; when 0 all outputs hold
- a      input   1  operand A bit of this significance
- b      input   1  operand B bit of this significance
- in_g   input   1  cascade in: lower bits say A>B
- in_eq  input   1  cascade in: lower bits say A==B
- in_l   input   1  cascade in: lower bits say A<B
- G      output  1  registered: A>B up to and including this bit
- Eq     output  1  registered: A==B up to and including this bit
- L      output  1  registered: A<B up to and including this bit
- err    output  1  registered: cascade inputs were not one-hot in the last enabled cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n); all state updates on the rising edge of clk only.
- Reset: on a rising edge with rst_n=0, the outputs become G=0, Eq=1, L=0, err=0. Reset wins over en.
- Enabled update: on a rising edge with rst_n=1 and en=1, the next outputs are computed from the current inputs, in this priority:
  - a=1, b=0 -> G=1, Eq=0, L=0, regardless of cascade inputs.
  - a=0, b=1 -> G=0, Eq=0, L=1, regardless of cascade inputs.
  - a==b -> resolve the cascade. Priority in_g > in_l > in_eq:
    - in_g=1 -> G.
    - else in_l=1 -> L.
    - else in_eq=1 -> Eq.
    - all three 0 -> Eq.
- err next value = 1 iff {in_g,in_eq,in_l} is not exactly one-hot (zero or two or more asserted). It is evaluated independently of a/b.
- Hold: rst_n=1 and en=0 -> G, Eq, L and err all keep their values.
- Invariant: G/Eq/L is always exactly one-hot, including after reset and under malformed cascade inputs.
- Latency: one clock from input sample to output. An N-slice chain registers each slice, so consumers must align the operand pipeline with this.
- No combinational path from any input to any output.
- X-free: all outputs are defined from the first reset onward.

Test Plan:
- Reset: rst_n=0 for 2 clocks with random inputs -> G=0, Eq=1, L=0, err=0. Then rst_n=1, en=0 -> values held.
- Sweep with cascade forced: in_g=1, in_eq=0, in_l=0, en=1, {a,b} stepped 00,01,10,11, one clock each. After each edge, {G,Eq,L} must be 100, 001, 100, 100; err=0.
- Pass-through: a=b=1. Set in_eq=1 -> Eq=1. Then in_l=1 alone -> L=1. Then in_g=1 alone -> G=1. err=0 throughout.
- Malformed cascade: a=b=0.
  - in_g=in_l=1 -> G=1, err=1.
  - in_l=in_eq=1 -> L=1, err=1.
  - all 0 -> Eq=1, err=1.
  - a=1, b=0 with all cascade inputs 0 -> G=1, err=1.
- Enable/reset interaction: change inputs with en=0 -> outputs unchanged. Assert rst_n=0 while en=0 -> reset values on the next edge.
- 4-slice chain (LSB in_eq=1): A=4'b1010, B=4'b1001 -> MSB slice G=1, with inputs held stable until the result propagates (4 clocks). Repeat with A=B=4'b0110 -> Eq=1.
